// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// key_pkg : shared types and sizes for the RSA modulus generator
// Revision: 1.0
// ============================================================================
package key_pkg;

  localparam int WORDSIZE_DEF = 32;
  localparam int REJ_W        = 16;

  typedef enum logic [1:0] {
    GET_P = 2'd0,
    GET_Q = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } key_state_t;

endpackage
`default_nettype wire

// File: rtl/rsa_modulus_gen_if.sv
`default_nettype none
// ============================================================================
// rsa_modulus_gen_if : candidate intake and key delivery signals
// Revision: 1.0
// ============================================================================
interface rsa_modulus_gen_if
  import key_pkg::*;
#(
  parameter int WORDSIZE = WORDSIZE_DEF
);
  logic [WORDSIZE-1:0]   cand;
  logic                  cand_valid;
  logic                  cand_is_prime;
  logic                  cand_ready;
  logic [WORDSIZE-1:0]   p_out;
  logic [WORDSIZE-1:0]   q_out;
  logic [2*WORDSIZE-1:0] n_out;
  logic [2*WORDSIZE-1:0] phi_out;
  logic                  key_valid;
  logic                  key_ack;
  logic                  busy;
  logic [REJ_W-1:0]      reject_cnt;

  modport master (
    output cand, cand_valid, cand_is_prime, key_ack,
    input  cand_ready, p_out, q_out, n_out, phi_out, key_valid, busy, reject_cnt
  );

  modport slave (
    input  cand, cand_valid, cand_is_prime, key_ack,
    output cand_ready, p_out, q_out, n_out, phi_out, key_valid, busy, reject_cnt
  );
endinterface
`default_nettype wire

// File: rtl/shift_add_mul.sv
`default_nettype none
// ============================================================================
// shift_add_mul : sequential multiplier, one multiplier bit per cycle
// Revision: 1.0
// ============================================================================
module shift_add_mul #(
  parameter int WORDSIZE = 32
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  start,
  input  wire logic [WORDSIZE-1:0]   a,
  input  wire logic [WORDSIZE-1:0]   b,
  output logic      [2*WORDSIZE-1:0] product,
  output logic                       done
);
  localparam int CNT_W = (WORDSIZE > 1) ? $clog2(WORDSIZE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDSIZE - 1);

  logic [2*WORDSIZE-1:0] acc;
  logic [2*WORDSIZE-1:0] mcand;
  logic [WORDSIZE-1:0]   mplier;
  logic [CNT_W-1:0]      cnt;
  logic                  running;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      mcand   <= {{WORDSIZE{1'b0}}, a};
      mplier  <= b;
      cnt     <= '0;
      running <= 1'b1;
      done    <= 1'b0;
    end else if (running) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (cnt == LAST) begin
        running <= 1'b0;
        done    <= 1'b1;
      end
    end
  end

  assign product = acc;

endmodule
`default_nettype wire

// File: rtl/rsa_modulus_gen.sv
`default_nettype none
// ============================================================================
// rsa_modulus_gen : collects two distinct odd primes, builds n and phi
// Revision: 1.0
// ============================================================================
module rsa_modulus_gen
  import key_pkg::*;
#(
  parameter int WORDSIZE = WORDSIZE_DEF
) (
  input wire logic         clk,
  input wire logic         reset,
  rsa_modulus_gen_if.slave bus
);
  key_state_t            state;
  logic [WORDSIZE-1:0]   p_reg;
  logic [WORDSIZE-1:0]   q_reg;
  logic [2*WORDSIZE-1:0] n_reg;
  logic [2*WORDSIZE-1:0] phi_reg;
  logic [REJ_W-1:0]      rej_reg;
  logic                  ready_reg;
  logic                  valid_reg;
  logic                  busy_reg;

  logic                  take;
  logic                  reject;
  logic                  start_mul;
  logic [2*WORDSIZE-1:0] n_prod;
  logic [2*WORDSIZE-1:0] phi_prod;
  logic                  n_done;
  logic                  phi_done;

  assign take   = bus.cand_valid && ready_reg;
  assign reject = !bus.cand_is_prime || !bus.cand[0] ||
                  (bus.cand < WORDSIZE'(3)) ||
                  ((state == GET_Q) && (bus.cand == p_reg));
  // Multipliers load on the same edge that accepts q, so the WORDSIZE
  // bit-steps fill the following edges and the result lands one edge later.
  assign start_mul = take && !reject && (state == GET_Q);

  shift_add_mul #(.WORDSIZE(WORDSIZE)) u_mul_n (
    .clk     (clk),
    .reset   (reset),
    .start   (start_mul),
    .a       (p_reg),
    .b       (bus.cand),
    .product (n_prod),
    .done    (n_done)
  );

  shift_add_mul #(.WORDSIZE(WORDSIZE)) u_mul_phi (
    .clk     (clk),
    .reset   (reset),
    .start   (start_mul),
    .a       (p_reg - WORDSIZE'(1)),
    .b       (bus.cand - WORDSIZE'(1)),
    .product (phi_prod),
    .done    (phi_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= GET_P;
      p_reg     <= '0;
      q_reg     <= '0;
      n_reg     <= '0;
      phi_reg   <= '0;
      rej_reg   <= '0;
      ready_reg <= 1'b1;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      case (state)
        GET_P, GET_Q: begin
          if (take) begin
            if (reject) begin
              if (rej_reg != '1) begin
                rej_reg <= rej_reg + REJ_W'(1);
              end
            end else if (state == GET_P) begin
              p_reg <= bus.cand;
              state <= GET_Q;
            end else begin
              q_reg     <= bus.cand;
              state     <= MUL;
              ready_reg <= 1'b0;
              busy_reg  <= 1'b1;
            end
          end
        end
        MUL: begin
          if (n_done && phi_done) begin
            n_reg     <= n_prod;
            phi_reg   <= phi_prod;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.key_ack) begin
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            state     <= GET_P;
          end
        end
        default: begin
          state     <= GET_P;
          ready_reg <= 1'b1;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cand_ready = ready_reg;
  assign bus.p_out      = p_reg;
  assign bus.q_out      = q_reg;
  assign bus.n_out      = n_reg;
  assign bus.phi_out    = phi_reg;
  assign bus.key_valid  = valid_reg;
  assign bus.busy       = busy_reg;
  assign bus.reject_cnt = rej_reg;

endmodule
`default_nettype wire

// File: tb/tb_rsa_modulus_gen.sv
`default_nettype none
// ============================================================================
// tb_rsa_modulus_gen : randomized bench with an arithmetic reference model
// Revision: 1.0
// ============================================================================
module tb_rsa_modulus_gen;
  localparam int W = 32;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  // reference model state
  logic [W-1:0] m_p;
  logic [W-1:0] m_q;
  logic [15:0]  m_rej;
  int           m_phase;

  rsa_modulus_gen_if #(.WORDSIZE(W)) bus ();

  rsa_modulus_gen #(.WORDSIZE(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_p = '0; m_q = '0; m_rej = '0; m_phase = 0;
  endtask

  task automatic offer(input logic [W-1:0] c, input logic isp, input logic ack, output logic q_done);
    logic ok;
    bus.cand = c; bus.cand_is_prime = isp; bus.cand_valid = 1'b1; bus.key_ack = ack;
    step();
    bus.cand_valid = 1'b0; bus.key_ack = 1'b0;
    ok = isp && c[0] && (c >= 3) && !(m_phase == 1 && c == m_p);
    q_done = 1'b0;
    if (!ok) begin
      if (m_rej != 16'hFFFF) m_rej++;
    end else if (m_phase == 0) begin
      m_p = c; m_phase = 1;
    end else begin
      m_q = c; m_phase = 0; q_done = 1'b1;
    end
    check("reject_cnt", bus.reject_cnt, m_rej);
    check("p_out", bus.p_out, m_p);
    check("cand_ready", bus.cand_ready, q_done ? 1'b0 : 1'b1);
  endtask

  task automatic wait_key();
    int cyc = 0;
    int changes = 0;
    logic [63:0] n_prev = bus.n_out;
    logic [63:0] phi_prev = bus.phi_out;
    while (!bus.key_valid && cyc < 200) begin
      if (cyc == 1) check("busy_in_mul", bus.busy, 1'b1);
      step();
      cyc++;
      if (!bus.key_valid && (bus.n_out !== n_prev || bus.phi_out !== phi_prev)) changes++;
    end
    check("key_latency", cyc, W + 1);
    check("no_partial", changes, 0);
  endtask

  task automatic ack_key();
    bus.key_ack = 1'b1;
    step();
    bus.key_ack = 1'b0;
    check("valid_after_ack", bus.key_valid, 1'b0);
    check("ready_after_ack", bus.cand_ready, 1'b1);
  endtask

  task automatic finish_key(input logic do_ack);
    longint unsigned en, ephi;
    en   = longint'(m_p) * longint'(m_q);
    ephi = (longint'(m_p) - 1) * (longint'(m_q) - 1);
    wait_key();
    check("n_out", bus.n_out, en);
    check("phi_out", bus.phi_out, ephi);
    check("q_out", bus.q_out, m_q);
    check("busy_done", bus.busy, 1'b0);
    if (do_ack) ack_key();
  endtask

  initial begin
    logic qd;
    logic [63:0] hold_n;
    n_chk = 0; n_err = 0;
    bus.cand = '0; bus.cand_valid = 1'b0; bus.cand_is_prime = 1'b0; bus.key_ack = 1'b0;
    model_reset();
    reset = 1'b0;
    step(); step();
    check("rst_p", bus.p_out, 0);
    check("rst_q", bus.q_out, 0);
    check("rst_n", bus.n_out, 0);
    check("rst_phi", bus.phi_out, 0);
    check("rst_rej", bus.reject_cnt, 0);
    check("rst_valid", bus.key_valid, 0);
    check("rst_busy", bus.busy, 0);
    @(negedge clk); reset = 1'b1;
    step();
    check("rst_ready", bus.cand_ready, 1'b1);

    // basic key
    offer(61, 1, 0, qd);
    offer(53, 1, 0, qd);
    check("basic_accept", qd, 1'b1);
    finish_key(1'b0);
    check("basic_n", bus.n_out, 64'd3233);
    check("basic_phi", bus.phi_out, 64'd3120);
    ack_key();

    // duplicate prime in GET_Q
    offer(61, 1, 0, qd);
    offer(61, 1, 0, qd);
    check("dup_rej", bus.reject_cnt, 1);
    check("dup_busy", bus.busy, 1'b0);
    offer(53, 1, 0, qd);
    finish_key(1'b0);
    check("dup_n", bus.n_out, 64'd3233);
    ack_key();

    // composite and even in GET_P
    offer(15, 0, 0, qd);
    offer(2, 1, 0, qd);
    check("comp_rej", bus.reject_cnt, 3);
    check("comp_p_kept", bus.p_out, 61);

    // width extremes, then hold in DONE with cand_valid toggling
    offer(32'hFFFFFFFB, 1, 0, qd);
    offer(32'hFFFFFFEF, 1, 0, qd);
    finish_key(1'b0);
    check("ext_n", bus.n_out, 64'hFFFFFFEA00000055);
    check("ext_phi", bus.phi_out, 64'hFFFFFFE80000006C);
    hold_n = bus.n_out;
    for (int i = 0; i < 20; i++) begin
      bus.cand = $urandom() | 32'h1;
      bus.cand_is_prime = 1'b1;
      bus.cand_valid = i[0];
      step();
      check("hold_n", bus.n_out, hold_n);
      check("hold_p", bus.p_out, m_p);
      check("hold_rej", bus.reject_cnt, m_rej);
      check("hold_valid", bus.key_valid, 1'b1);
    end
    bus.cand_valid = 1'b0;
    ack_key();

    // reset abort mid-multiply
    offer(101, 1, 0, qd);
    offer(103, 1, 0, qd);
    repeat (10) step();
    reset = 1'b0;
    #1;
    model_reset();
    check("abort_n", bus.n_out, 0);
    check("abort_phi", bus.phi_out, 0);
    check("abort_p", bus.p_out, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_rej", bus.reject_cnt, 0);
    @(negedge clk); reset = 1'b1;
    offer(107, 1, 0, qd);
    offer(109, 1, 0, qd);
    finish_key(1'b1);

    // randomized keys
    for (int k = 0; k < 6; k++) begin
      int tries = 0;
      qd = 1'b0;
      while (!qd && tries < 200) begin
        logic [W-1:0] c;
        int r = $urandom_range(0, 9);
        tries++;
        if ($urandom_range(0, 3) == 0) begin
          step();
          continue;
        end
        if (r < 2) c = W'($urandom_range(0, 4));
        else if (r == 2 && m_phase == 1) c = m_p;
        else if (r == 3) c = $urandom() & ~32'h1;
        else c = $urandom();
        offer(c, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), qd);
      end
      check("rand_key_done", qd, 1'b1);
      if (qd) finish_key(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rsa_modulus_gen.md
RSA_MODULUS_GEN -- requirements
Module: rsa_modulus_gen

Interface
REQ-001 The block SHALL have parameter WORDSIZE, default 32, giving the prime width in bits; the product width is 2*WORDSIZE.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port cand, input, WORDSIZE bits: candidate number from the primality tester.
REQ-005 The block SHALL have port cand_valid, input, 1 bit: the tester's finish strobe; qualifies cand and cand_is_prime.
REQ-006 The block SHALL have port cand_is_prime, input, 1 bit: the tester's verdict on cand.
REQ-007 The block SHALL have port cand_ready, output, 1 bit: the block can accept a candidate this cycle.
REQ-008 The block SHALL have ports p_out and q_out, outputs, WORDSIZE bits each: the accepted primes.
REQ-009 The block SHALL have port n_out, output, 2*WORDSIZE bits: the modulus p*q.
REQ-010 The block SHALL have port phi_out, output, 2*WORDSIZE bits: (p-1)*(q-1).
REQ-011 The block SHALL have port key_valid, output, 1 bit: p_out, q_out, n_out and phi_out are complete and stable.
REQ-012 The block SHALL have port key_ack, input, 1 bit: the consumer has taken the key.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in MUL.
REQ-014 The block SHALL have port reject_cnt, output, 16 bits: count of discarded candidates.

Function
REQ-015 The FSM SHALL have exactly four states: GET_P, GET_Q, MUL, DONE.
REQ-016 cand_ready SHALL be high only in GET_P and GET_Q.
REQ-017 A candidate SHALL be taken on a rising edge only when cand_valid and cand_ready are both high; cand_valid in other states SHALL be ignored and not counted.
REQ-018 A taken candidate SHALL be rejected if cand_is_prime=0, or cand[0]=0, or cand<3, or (in GET_Q) cand==p.
REQ-019 A rejected candidate SHALL leave the state unchanged and increment reject_cnt, saturating at 16'hFFFF.
REQ-020 In GET_P, an accepted candidate SHALL be stored as p, and the FSM SHALL move to GET_Q.
REQ-021 In GET_Q, an accepted candidate SHALL be stored as q, and the FSM SHALL move to MUL.
REQ-022 MUL SHALL compute n=p*q and phi=(p-1)*(q-1) concurrently by shift-and-add, consuming one multiplier bit per cycle, for exactly WORDSIZE cycles.
REQ-023 Products SHALL be exact in 2*WORDSIZE bits, with no truncation.
REQ-024 key_valid SHALL rise exactly WORDSIZE+1 rising edges after the edge that accepted q.
REQ-025 The FSM SHALL enter DONE from MUL on that same edge.
REQ-026 In DONE, key_valid SHALL stay high and all four result outputs SHALL stay constant until key_ack is sampled high.
REQ-027 On key_ack high in DONE, the FSM SHALL move to GET_P, and key_valid SHALL be low from the next cycle.
REQ-028 key_ack in any other state SHALL be ignored.
REQ-029 n_out and phi_out SHALL expose only completed results; intermediate accumulator values SHALL never appear on them.
REQ-030 p_out and q_out SHALL update only on acceptance.
REQ-031 reject_cnt SHALL keep counting across keys and clear only on reset.

Reset
REQ-032 While reset=0, the FSM SHALL be in GET_P.
REQ-033 While reset=0, p_out, q_out, n_out, phi_out, reject_cnt, key_valid and busy SHALL be 0, and cand_ready SHALL be 1 after release.
REQ-034 Reset asserted mid-MUL or in DONE SHALL abort immediately, with no partial result retained.

Structure
REQ-035 Package key_pkg SHALL hold the FSM state enum, the default WORDSIZE and the reject-counter width (16).
REQ-036 One sub-module, shift_add_mul (WORDSIZE-parameterised, with start/done), SHALL be instantiated twice: once for n and once for phi.

Verification
REQ-037 Basic key: p=61 then q=53, both with is_prime=1 -> key_valid after 33 edges; n_out=3233, phi_out=3120, reject_cnt=0.
REQ-038 Duplicate prime: p=61, then 61 again with is_prime=1 -> rejected, reject_cnt=1, FSM stays in GET_Q; next q=53 -> n_out=3233.
REQ-039 Composite and even: cand=15 with is_prime=0, then cand=2 with is_prime=1 -> both rejected, reject_cnt=2, FSM still in GET_P.
REQ-040 Width extremes: p=0xFFFFFFFB, q=0xFFFFFFEF -> n_out=0xFFFFFFEA00000055, phi_out=0xFFFFFFE80000006C.
REQ-041 Reset abort: assert reset at cycle 10 of MUL -> all outputs 0; a fresh p/q pair afterwards produces the correct key.
REQ-042 Hold and ack: hold key_ack low for 20 cycles in DONE with cand_valid toggling -> outputs stable, nothing accepted, reject_cnt unchanged; pulse key_ack -> key_valid low on the next cycle, cand_ready high.
